// File: rtl/mem_req_arb.sv
// mem_req_arb
// -----------------------------------------------------------------------------
// Arbitrates read requests from NUM_CH cache miss-handler channels onto a single
// SDRAM controller read port.  One channel is granted at a time.  Its address and
// word count are latched at grant, so the channel may change them afterwards.
// Returned words are steered back to the granted channel with zero latency.
// A one-cycle completion pulse is issued after the last word.
//
// Ports
//   clk, rst            : single clock, synchronous active-low reset
//   ch_readReq          : per-channel request, held until that channel's ch_doneRead
//   ch_addr             : per-channel start address, channel i at [i*ADDR_W +: ADDR_W]
//   ch_transSize        : per-channel word count, channel i at [i*TS_W +: TS_W];
//                         a count of 0 means MAX_TRANS words
//   ch_readValid_out    : per-channel read-word strobe (at most one bit high)
//   ch_readData         : mem_readData replicated to every channel
//   ch_doneRead         : one-cycle completion pulse for the granted channel
//   mem_readReq         : request to the SDRAM controller
//   mem_addr            : latched address of the granted channel
//   mem_transSize       : latched size of the granted channel
//   mem_ack             : controller accepted the request
//   mem_readValid       : controller returns a word on mem_readData
//   busy                : arbiter is not idle
// -----------------------------------------------------------------------------
module mem_req_arb #(
    parameter int NUM_CH    = 3,
    parameter int ADDR_W    = 25,
    parameter int DATA_W    = 32,
    parameter int MAX_TRANS = 16,
    parameter int PRIO_MODE = 0,
    localparam int TS_W     = $clog2(MAX_TRANS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_readReq,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*TS_W-1:0]   ch_transSize,
    output logic [NUM_CH-1:0]        ch_readValid_out,
    output logic [NUM_CH*DATA_W-1:0] ch_readData,
    output logic [NUM_CH-1:0]        ch_doneRead,
    output logic                     mem_readReq,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [TS_W-1:0]          mem_transSize,
    input  logic                     mem_ack,
    input  logic                     mem_readValid,
    input  logic [DATA_W-1:0]        mem_readData,
    output logic                     busy
);

    localparam int GW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW = TS_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;
    logic [GW-1:0]     grant_r;
    logic [GW-1:0]     rr_ptr_r;
    logic [GW-1:0]     rr_next_s;
    logic [GW-1:0]     sel_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [TS_W-1:0]   size_r;
    logic [TS_W-1:0]   sel_size_s;
    logic [CW-1:0]     cnt_r;
    logic [CW-1:0]     last_idx_s;
    logic              found_s;
    logic              last_word_s;

    // Grant search: first requester at or after the start point, wrapping.
    // Fixed priority simply starts the search at channel 0.
    always_comb begin
        int base_v;
        int idx_v;
        sel_s      = '0;
        sel_addr_s = '0;
        sel_size_s = '0;
        found_s    = 1'b0;
        idx_v      = 0;
        if (PRIO_MODE == 0) begin
            base_v = int'(rr_ptr_r);
        end else begin
            base_v = 0;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            idx_v = (base_v + i) % NUM_CH;
            if (!found_s && ch_readReq[idx_v]) begin
                found_s    = 1'b1;
                sel_s      = GW'(idx_v);
                sel_addr_s = ch_addr[idx_v*ADDR_W +: ADDR_W];
                sel_size_s = ch_transSize[idx_v*TS_W +: TS_W];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Index of the final word (size 0 stands for MAX_TRANS) and pointer advance.
    always_comb begin
        if (size_r == '0) begin
            last_idx_s = CW'(MAX_TRANS - 1);
        end else begin
            last_idx_s = CW'(size_r) - CW'(1);
        end
        if (grant_r == GW'(NUM_CH - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = grant_r + GW'(1);
        end
        last_word_s = mem_readValid && (cnt_r == last_idx_s);
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (found_s) state_nx_s = REQ;
                else         state_nx_s = IDLE;
            end
            REQ: begin
                if (mem_ack) state_nx_s = DATA;
                else         state_nx_s = REQ;
            end
            DATA: begin
                if (last_word_s) state_nx_s = DONE;
                else             state_nx_s = DATA;
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Grant, address and size are captured only at the grant edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            grant_r <= '0;
            addr_r  <= '0;
            size_r  <= '0;
        end else if (state_r == IDLE && found_s) begin
            grant_r <= sel_s;
            addr_r  <= sel_addr_s;
            size_r  <= sel_size_s;
        end else begin
            grant_r <= grant_r;
            addr_r  <= addr_r;
            size_r  <= size_r;
        end
    end

    // Word counter: cleared on acceptance, advanced per returned word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r <= '0;
        end else if (state_r == REQ && mem_ack) begin
            cnt_r <= '0;
        end else if (state_r == DATA && mem_readValid) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Round-robin pointer moves past the channel just served.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr_r <= '0;
        end else if (state_r == DONE && PRIO_MODE == 0) begin
            rr_ptr_r <= rr_next_s;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Read data is broadcast; only the strobe says which channel owns it.
    assign ch_readData = {NUM_CH{mem_readData}};

    // Output decode; everything is forced low while reset is asserted.
    always_comb begin
        mem_readReq      = 1'b0;
        busy             = 1'b0;
        mem_addr         = '0;
        mem_transSize    = '0;
        ch_readValid_out = '0;
        ch_doneRead      = '0;
        if (rst) begin
            mem_readReq   = (state_r == REQ);
            busy          = (state_r != IDLE);
            mem_addr      = addr_r;
            mem_transSize = size_r;
            if (state_r == DATA && mem_readValid) begin
                ch_readValid_out[grant_r] = 1'b1;
            end else begin
                ch_readValid_out = '0;
            end
            if (state_r == DONE) begin
                ch_doneRead[grant_r] = 1'b1;
            end else begin
                ch_doneRead = '0;
            end
        end else begin
            mem_readReq = 1'b0;
        end
    end

endmodule
